// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, waits on data-SRAM, aligns/extends load data.
// Latency: one edge for non-memory ops; memory ops present in the data_ok cycle or later once buffered.
// Backpressure: holds while ws_allowin is low; a response arriving during a stall is buffered until handoff.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [74:0] es_to_ms_bus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  output logic [38:0] ms_to_ds_bus
);

  typedef struct packed {
    logic        mem_req;
    logic [2:0]  ld_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ws_bus_t;

  typedef struct packed {
    logic        load_pending;
    logic        fwd_we;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_result;
  } ds_bus_t;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  logic        ms_valid;
  es_bus_t     ms_bus_r;
  logic        buf_valid;
  logic [31:0] buf_rdata;

  logic        ms_ready_go;
  logic [31:0] mem_rdata;
  logic [1:0]  sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_result;
  logic [31:0] final_result;
  ws_bus_t     ws_bus;
  ds_bus_t     ds_bus;

  // A memory op may leave once its response is either on the wire now or already buffered.
  assign ms_ready_go    = !ms_bus_r.mem_req || data_sram_data_ok || buf_valid;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  // The buffered copy wins so the result stays stable after the SRAM moves on.
  assign mem_rdata = buf_valid ? buf_rdata : data_sram_rdata;
  assign sh        = ms_bus_r.alu_result[1:0];

  // Pick the addressed byte and halfword out of the response word.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (sh)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = sh[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Extend according to the load flavour; unknown encodings behave as a full word.
  always_comb begin
    load_result = mem_rdata;
    case (ms_bus_r.ld_op)
      LD_B:    load_result = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   load_result = {24'd0, ld_byte};
      LD_H:    load_result = {{16{ld_half[15]}}, ld_half};
      LD_HU:   load_result = {16'd0, ld_half};
      LD_W:    load_result = mem_rdata;
      default: load_result = mem_rdata;
    endcase
  end

  assign final_result = ms_bus_r.res_from_mem ? load_result : ms_bus_r.alu_result;

  assign ws_bus.gr_we        = ms_bus_r.gr_we;
  assign ws_bus.dest         = ms_bus_r.dest;
  assign ws_bus.final_result = final_result;
  assign ws_bus.pc           = ms_bus_r.pc;
  assign ms_to_ws_bus        = ws_bus;

  // A load still waiting on data cannot be forwarded, so decode must stall on a dest match.
  assign ds_bus.load_pending = ms_valid && ms_bus_r.res_from_mem && !ms_ready_go;
  assign ds_bus.fwd_we       = ms_valid && ms_bus_r.gr_we;
  assign ds_bus.fwd_dest     = ms_bus_r.dest;
  assign ds_bus.fwd_result   = final_result;
  assign ms_to_ds_bus        = ds_bus;

  // Stage occupancy follows the upstream valid whenever we can accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Capture the execute bus on a successful upstream handshake.
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      ms_bus_r <= es_to_ms_bus;
    end
  end

  // Track whether a response is held for a stalled instruction; cleared on handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
    end else if (ms_to_ws_valid && ws_allowin) begin
      buf_valid <= 1'b0;
    end else if (ms_valid && ms_bus_r.mem_req && data_sram_data_ok && !ws_allowin) begin
      buf_valid <= 1'b1;
    end
  end

  // Hold the response word while writeback is not accepting.
  always_ff @(posedge clk) begin
    if (ms_valid && ms_bus_r.mem_req && data_sram_data_ok && !ws_allowin && !buf_valid) begin
      buf_rdata <= data_sram_rdata;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and the writeback stage. Registers the execute-stage bus and waits for the data-SRAM response of any outstanding load/store. Aligns and extends load data, then drives the ms→ws valid/allowin handshake and the 70-bit writeback bus consumed by the writeback stage. Also exports a bypass/hazard bus to decode.

## Interface
Parameters: none; widths come from `mycpu.v` (`ES_TO_MS_BUS_WD`=75, `MS_TO_WS_BUS_WD`=70, `MS_TO_DS_BUS_WD`=39).

Ports:
- clk  in  1  clock; all state on posedge
- reset  in  1  synchronous, active-high
- ws_allowin  in  1  writeback stage can accept this cycle
- ms_allowin  out  1  mem stage can accept from execute
- es_to_ms_valid  in  1  execute presents a valid instruction
- es_to_ms_bus  in  75  {mem_req[74], ld_op[73:71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- data_sram_data_ok  in  1  one-cycle pulse: response for the single outstanding request
- data_sram_rdata  in  32  load data, valid with data_ok
- ms_to_ws_valid  out  1  writeback bus valid
- ms_to_ws_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- ms_to_ds_bus  out  39  {load_pending[38], fwd_we[37], fwd_dest[36:32], fwd_result[31:0]}

ld_op encoding: 000 ld.w, 001 ld.b, 010 ld.h, 011 ld.bu, 100 ld.hu; others are treated as ld.w.

## Operation
- State:
  - ms_valid
  - bus register ms_bus_r (75 b)
  - data buffer buf_rdata (32 b) with buf_valid
- Capture: on es_to_ms_valid && ms_allowin, ms_bus_r <= es_to_ms_bus.
- Valid update: if ms_allowin, ms_valid <= es_to_ms_valid.
- ms_ready_go = !mem_req || data_sram_data_ok || buf_valid.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go.
- Buffering (stall with response in hand):
  - Set: when ms_valid && mem_req && data_ok && !ws_allowin, buf_rdata <= rdata and buf_valid <= 1.
  - Clear: buf_valid clears when ms_to_ws_valid && ws_allowin.
  - Simultaneous clear and set cannot happen, because set requires !ws_allowin.
- Response data source: mem_rdata = buf_valid ? buf_rdata : data_sram_rdata.
- Load alignment uses sh = alu_result[1:0]:
  - ld.b / ld.bu: byte = mem_rdata[8*sh +: 8], then sign-extend (ld.b) or zero-extend (ld.bu) to 32.
  - ld.h / ld.hu: half = sh[1] ? mem_rdata[31:16] : mem_rdata[15:0], then sign-/zero-extend.
  - ld.w: mem_rdata unchanged; sh is ignored (misalignment is trapped upstream).
- final_result = res_from_mem ? load_result : alu_result.
- Stores use mem_req=1, res_from_mem=0, and wait for data_ok like loads.
- ms_to_ws_bus = {gr_we, dest, final_result, pc}, driven from registered fields.
- Bypass bus:
  - fwd_we = ms_valid && gr_we
  - fwd_dest = dest
  - fwd_result = final_result
  - load_pending = ms_valid && res_from_mem && !ms_ready_go (decode must stall on a dest match)
- data_ok arriving while !ms_valid or !mem_req is ignored (no buffer update).

## Timing
- Reset (synchronous):
  - ms_valid=0, buf_valid=0
  - hence ms_to_ws_valid=0, ms_allowin=1, load_pending=0, fwd_we=0
  - ms_bus_r and buf_rdata are don't-care
- Latency: an instruction with mem_req=0 is captured at edge N and presented on ms_to_ws_valid in cycle N (after the edge); it is handed off at edge N+1 if ws_allowin.
- With mem_req=1: presented in the cycle data_ok is high, or in any later cycle once buffered.
- Handshake:
  - Transfer occurs only on a cycle with ms_to_ws_valid && ws_allowin.
  - The bus stays stable while ms_to_ws_valid && !ws_allowin.
- Back-to-back: if ms_allowin in the transfer cycle, a new instruction is captured on the same edge; throughput is 1/cycle with no memory waits.
- Reset mid-operation: a reset while waiting for data_ok drops the instruction and the buffer. A data_ok arriving in the reset cycle is discarded.

## Test plan
- Non-memory op with alu_result=0x0000_1234, dest=5, gr_we=1, ws_allowin=1 -> next cycle ms_to_ws_bus={1,5,0x00001234,pc}, ms_to_ws_valid=1; three back-to-back ops issue three consecutive valid cycles.
- ld.b, addr[1:0]=3, rdata=0x80FF_0011, data_ok 2 cycles after capture:
  - load_pending=1 and ms_to_ws_valid=0 for 2 cycles
  - then final_result=0xFFFF_FF80
- Alignment sweep with rdata=0x8001_7F02:
  - ld.bu sh=2 -> 0x0000_0001
  - ld.h sh=2 -> 0xFFFF_8001
  - ld.hu sh=0 -> 0x0000_7F02
  - ld.w -> 0x8001_7F02
- ld.w with data_ok=1, rdata=0xDEAD_BEEF while ws_allowin=0 for 3 cycles, rdata then changed to 0:
  - buf_valid=1, and the bus holds 0xDEADBEEF through the stall
  - transfers when ws_allowin=1; buf_valid=0 afterwards
- Store (mem_req=1, res_from_mem=0): ms_to_ws_valid stays 0 until data_ok; then asserts with final_result=alu_result.
- Assert reset for one cycle while a load waits on data_ok -> ms_to_ws_valid=0 and ms_allowin=1 after the edge; a data_ok in the following cycle produces no output.
